// File: rtl/nios_ii_system_cpu_mult_pipe.sv
// Three-stage pipelined DATA_W x DATA_W multiplier (MUL / MULXSS / MULXSU / MULXUU) with tag sideband.
// Optional synchronous pipeline flush is enabled by defining MULT_PIPE_FLUSH_EN.
module nios_ii_system_cpu_mult_pipe #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag
`ifdef MULT_PIPE_FLUSH_EN
   ,
   input  logic              flush
`endif
);

   localparam int HALF_W = DATA_W / 2;
   localparam int PP_W   = DATA_W + 2;
   localparam int PROD_W = 2 * DATA_W;

   logic flush_i;
`ifdef MULT_PIPE_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   logic              s1_valid_q, s1_valid_d;
   logic [1:0]        s1_op_q, s1_op_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

   logic              s2_valid_q, s2_valid_d;
   logic              s2_hi_sel_q, s2_hi_sel_d;
   logic [PP_W-1:0]   s2_ll_q, s2_ll_d;
   logic [PP_W-1:0]   s2_lh_q, s2_lh_d;
   logic [PP_W-1:0]   s2_hl_q, s2_hl_d;
   logic [PP_W-1:0]   s2_hh_q, s2_hh_d;
   logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;

   logic              s3_valid_q, s3_valid_d;
   logic [DATA_W-1:0] s3_result_q, s3_result_d;
   logic [TAG_W-1:0]  s3_tag_q, s3_tag_d;

   logic              stall;
   logic              a_sgn, b_sgn;
   logic [HALF_W:0]   a_hi, a_lo, b_hi, b_lo;
   logic [PROD_W-1:0] prod;

   // Each half is widened by one bit: high halves carry the operand sign when the op is signed,
   // low halves are always non-negative, so every partial product is a plain signed multiply.
   function automatic logic signed [PP_W-1:0] ext_pp(input logic [HALF_W:0] x);
      return {{(PP_W-HALF_W-1){x[HALF_W]}}, x};
   endfunction

   function automatic logic [PROD_W-1:0] ext_prod(input logic [PP_W-1:0] x);
      return {{(PROD_W-PP_W){x[PP_W-1]}}, x};
   endfunction

   always_comb begin
      stall    = s3_valid_q && !out_ready;
      in_ready = !stall && !flush_i;

      a_sgn = (s1_op_q == 2'b01) || (s1_op_q == 2'b10);
      b_sgn = (s1_op_q == 2'b01);
      a_hi  = {a_sgn & s1_a_q[DATA_W-1], s1_a_q[DATA_W-1:HALF_W]};
      a_lo  = {1'b0, s1_a_q[HALF_W-1:0]};
      b_hi  = {b_sgn & s1_b_q[DATA_W-1], s1_b_q[DATA_W-1:HALF_W]};
      b_lo  = {1'b0, s1_b_q[HALF_W-1:0]};

      prod = ext_prod(s2_ll_q)
           + ((ext_prod(s2_lh_q) + ext_prod(s2_hl_q)) << HALF_W)
           + (ext_prod(s2_hh_q) << DATA_W);

      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_tag_d    = s1_tag_q;
      s2_valid_d  = s2_valid_q;
      s2_hi_sel_d = s2_hi_sel_q;
      s2_ll_d     = s2_ll_q;
      s2_lh_d     = s2_lh_q;
      s2_hl_d     = s2_hl_q;
      s2_hh_d     = s2_hh_q;
      s2_tag_d    = s2_tag_q;
      s3_valid_d  = s3_valid_q;
      s3_result_d = s3_result_q;
      s3_tag_d    = s3_tag_q;

      if (!stall) begin
         s1_valid_d = in_valid && in_ready;
         if (in_valid && in_ready) begin
            s1_op_d  = in_op;
            s1_a_d   = in_src1;
            s1_b_d   = in_src2;
            s1_tag_d = in_tag;
         end

         s2_valid_d  = s1_valid_q;
         s2_hi_sel_d = (s1_op_q != 2'b00);
         s2_ll_d     = ext_pp(a_lo) * ext_pp(b_lo);
         s2_lh_d     = ext_pp(a_lo) * ext_pp(b_hi);
         s2_hl_d     = ext_pp(a_hi) * ext_pp(b_lo);
         s2_hh_d     = ext_pp(a_hi) * ext_pp(b_hi);
         s2_tag_d    = s1_tag_q;

         s3_valid_d  = s2_valid_q;
         s3_result_d = s2_hi_sel_q ? prod[PROD_W-1:DATA_W] : prod[DATA_W-1:0];
         s3_tag_d    = s2_tag_q;
      end

      // Flush drops every in-flight op; data registers are left as they are.
      if (flush_i) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
         s3_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_hi_sel_q <= 1'b0;
         s2_ll_q     <= '0;
         s2_lh_q     <= '0;
         s2_hl_q     <= '0;
         s2_hh_q     <= '0;
         s2_tag_q    <= '0;
         s3_valid_q  <= 1'b0;
         s3_result_q <= '0;
         s3_tag_q    <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         s2_hi_sel_q <= s2_hi_sel_d;
         s2_ll_q     <= s2_ll_d;
         s2_lh_q     <= s2_lh_d;
         s2_hl_q     <= s2_hl_d;
         s2_hh_q     <= s2_hh_d;
         s2_tag_q    <= s2_tag_d;
         s3_valid_q  <= s3_valid_d;
         s3_result_q <= s3_result_d;
         s3_tag_q    <= s3_tag_d;
      end
   end

   assign out_valid  = s3_valid_q;
   assign out_result = s3_result_q;
   assign out_tag    = s3_tag_q;

endmodule
